// File: rtl/ifetch_sched_lru.sv
// Fetch-stage thread scheduler: round-robin fetch arbiter, icache-miss sleep mask,
// and per-set 4-way tree pseudo-LRU state for fill victim selection.
module ifetch_sched_lru #(
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned NUM_WAYS    = 4,
  parameter int unsigned NUM_SETS    = 64,
  localparam int unsigned ThreadW    = $clog2(NUM_THREADS),
  localparam int unsigned WayW       = $clog2(NUM_WAYS),
  localparam int unsigned SetW       = $clog2(NUM_SETS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_THREADS-1:0] fetch_en,
  input  logic                   update_lru,
  output logic [NUM_THREADS-1:0] grant_oh,
  output logic [ThreadW-1:0]     grant_idx,
  input  logic                   miss_en,
  input  logic [ThreadW-1:0]     miss_thread_idx,
  input  logic [NUM_THREADS-1:0] wake_bitmap,
  output logic [NUM_THREADS-1:0] wait_threads,
  input  logic                   fill_en,
  input  logic [SetW-1:0]        fill_set,
  output logic [WayW-1:0]        fill_way,
  input  logic                   access_en,
  input  logic [SetW-1:0]        access_set,
  input  logic                   access_update_en,
  input  logic [WayW-1:0]        access_update_way
);

  // Tree bits {b2, b1, b0}: b0 picks the half, b1/b2 pick the way within each half.
  function automatic logic [1:0] plru_victim(input logic [2:0] b);
    return {b[0], (b[0] ? b[2] : b[1])};
  endfunction

  function automatic logic [2:0] plru_touch(input logic [2:0] b, input logic [1:0] way);
    logic [2:0] r;
    r    = b;
    r[0] = ~way[1];
    if (way[1]) r[2] = ~way[0];
    else        r[1] = ~way[0];
    return r;
  endfunction

  logic [ThreadW-1:0]     rr_q, rr_d;
  logic [NUM_THREADS-1:0] wait_q, wait_d;
  logic [NUM_THREADS-1:0] req;
  logic [NUM_THREADS-1:0] miss_oh;
  logic [ThreadW-1:0]     cand;
  logic                   found;

  logic [NUM_SETS-1:0][2:0] plru_q, plru_d;
  logic [SetW-1:0]          acc_set_q, acc_set_d;

  assign req          = fetch_en & ~wait_q;
  assign wait_threads = wait_q;

  // Search upward from the pointer; power-of-two thread count makes the wrap a truncation.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < int'(NUM_THREADS); i++) begin
      cand = rr_q + ThreadW'(i);
      if (!found && req[cand]) begin
        found           = 1'b1;
        grant_idx       = cand;
        grant_oh[cand]  = 1'b1;
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (update_lru && found) rr_d = grant_idx + ThreadW'(1);
  end

  always_comb begin
    miss_oh = '0;
    if (miss_en) miss_oh[miss_thread_idx] = 1'b1;
    wait_d = (wait_q | miss_oh) & ~wake_bitmap;
  end

  assign fill_way = plru_victim(plru_q[fill_set]);

  // Fill touch lands first so a same-set access update ends up MRU.
  always_comb begin
    plru_d    = plru_q;
    acc_set_d = access_en ? access_set : acc_set_q;
    if (fill_en) plru_d[fill_set] = plru_touch(plru_q[fill_set], fill_way);
    if (access_update_en) begin
      plru_d[acc_set_q] = plru_touch(plru_d[acc_set_q], access_update_way);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q      <= '0;
      wait_q    <= '0;
      plru_q    <= '0;
      acc_set_q <= '0;
    end else begin
      rr_q      <= rr_d;
      wait_q    <= wait_d;
      plru_q    <= plru_d;
      acc_set_q <= acc_set_d;
    end
  end

endmodule

// File: tb/tb_ifetch_sched_lru.sv
// Bench for ifetch_sched_lru: directed scenarios plus random traffic against a
// recency-based model (MRU half and MRU way per half) of the replacement state.
module tb_ifetch_sched_lru;

  localparam int NT = 4;
  localparam int NS = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic [NT-1:0] fetch_en;
  logic          update_lru;
  logic [NT-1:0] grant_oh;
  logic [1:0]    grant_idx;
  logic          miss_en;
  logic [1:0]    miss_thread_idx;
  logic [NT-1:0] wake_bitmap;
  logic [NT-1:0] wait_threads;
  logic          fill_en;
  logic [5:0]    fill_set;
  logic [1:0]    fill_way;
  logic          access_en;
  logic [5:0]    access_set;
  logic          access_update_en;
  logic [1:0]    access_update_way;

  ifetch_sched_lru #(
    .NUM_THREADS(NT),
    .NUM_WAYS   (4),
    .NUM_SETS   (NS)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .fetch_en         (fetch_en),
    .update_lru       (update_lru),
    .grant_oh         (grant_oh),
    .grant_idx        (grant_idx),
    .miss_en          (miss_en),
    .miss_thread_idx  (miss_thread_idx),
    .wake_bitmap      (wake_bitmap),
    .wait_threads     (wait_threads),
    .fill_en          (fill_en),
    .fill_set         (fill_set),
    .fill_way         (fill_way),
    .access_en        (access_en),
    .access_set       (access_set),
    .access_update_en (access_update_en),
    .access_update_way(access_update_way)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  int m_ptr;
  bit m_wait[NT];
  int m_half[NS];     // half (0: ways 0/1, 1: ways 2/3) touched most recently
  int m_pair[NS][2];  // most recently touched way inside each half
  int m_acc;
  int m_g;
  int m_v;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_ptr = 0;
    m_acc = 0;
    for (int t = 0; t < NT; t++) m_wait[t] = 0;
    // All-zero tree bits mean way 0 is the victim: half 1 and ways 1/3 count as recent.
    for (int s = 0; s < NS; s++) begin
      m_half[s]    = 1;
      m_pair[s][0] = 1;
      m_pair[s][1] = 3;
    end
  endtask

  function automatic int m_victim(input int s);
    int h;
    h = 1 - m_half[s];
    return (m_pair[s][h] == 2 * h) ? 2 * h + 1 : 2 * h;
  endfunction

  task automatic m_touch(input int s, input int w);
    m_half[s]        = w / 2;
    m_pair[s][w / 2] = w;
  endtask

  function automatic int m_grant();
    for (int k = 0; k < NT; k++) begin
      int t;
      t = (m_ptr + k) % NT;
      if (fetch_en[t] && !m_wait[t]) return t;
    end
    return -1;
  endfunction

  // Let combinational outputs settle and compare them with the model.
  task automatic settle();
    logic [NT-1:0] exp_oh;
    logic [NT-1:0] exp_wait;
    #1;
    m_g = m_grant();
    m_v = m_victim(int'(fill_set));
    exp_oh = '0;
    if (m_g >= 0) exp_oh[m_g] = 1'b1;
    for (int t = 0; t < NT; t++) exp_wait[t] = m_wait[t];
    check_eq("grant_oh", grant_oh, exp_oh);
    check_eq("grant_idx", grant_idx, (m_g < 0) ? 0 : m_g);
    check_eq("wait_threads", wait_threads, exp_wait);
    check_eq("fill_way", fill_way, m_v);
  endtask

  task automatic tick();
    @(posedge clk);
    if (update_lru && m_g >= 0) m_ptr = (m_g + 1) % NT;
    for (int t = 0; t < NT; t++)
      m_wait[t] = (m_wait[t] || (miss_en && int'(miss_thread_idx) == t)) && !wake_bitmap[t];
    if (fill_en) m_touch(int'(fill_set), m_v);
    if (access_update_en) m_touch(m_acc, int'(access_update_way));
    if (access_en) m_acc = int'(access_set);
    #1;
  endtask

  task automatic idle();
    fetch_en = '0; update_lru = 0; miss_en = 0; miss_thread_idx = '0; wake_bitmap = '0;
    fill_en = 0; fill_set = '0; access_en = 0; access_set = '0;
    access_update_en = 0; access_update_way = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    m_reset();
    check_eq("rst_wait", wait_threads, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int seq[5];
    int fseq[5];
    reset = 1'b1;
    idle();
    do_reset();

    // Full-request round robin
    seq = '{0, 1, 2, 3, 0};
    fetch_en = 4'b1111; update_lru = 1;
    for (int i = 0; i < 5; i++) begin
      settle(); check_eq("rr_seq", grant_idx, seq[i]); tick();
    end

    // Pointer now 1: sparse request, then hold pointer
    fetch_en = 4'b0101; update_lru = 0;
    for (int i = 0; i < 4; i++) begin
      settle(); check_eq("rr_hold", grant_oh, 4'b0100); tick();
    end

    // Miss puts thread 2 to sleep
    fetch_en = 4'b1111; update_lru = 1; miss_en = 1; miss_thread_idx = 2;
    settle(); tick();
    miss_en = 0;
    for (int i = 0; i < 6; i++) begin
      settle();
      check_eq("sleep_mask", wait_threads, 4'b0100);
      check_eq("no_grant_t2", grant_oh[2], 0);
      tick();
    end
    wake_bitmap = 4'b0100;
    settle(); tick();
    wake_bitmap = '0;
    settle(); check_eq("wake_clear", wait_threads, 0); tick();
    miss_en = 1; wake_bitmap = 4'b0100;
    settle(); tick();
    miss_en = 0; wake_bitmap = '0;
    settle(); check_eq("wake_wins", wait_threads, 0); tick();

    // Mid-operation reset with a sleeping thread
    miss_en = 1; miss_thread_idx = 1;
    settle(); tick();
    miss_en = 0;
    do_reset();
    idle();

    // Fill victim sequence on set 5
    fseq = '{0, 2, 1, 3, 0};
    fill_set = 5;
    settle(); check_eq("rst_fill5", fill_way, 0);
    fill_en = 1;
    for (int i = 0; i < 5; i++) begin
      settle(); check_eq("fill_seq", fill_way, fseq[i]);
      if (i < 4) tick();
    end
    fill_en = 0;

    // Access latch then hit update on set 7
    access_en = 1; access_set = 7;
    settle(); tick();
    access_en = 0; access_update_en = 1; access_update_way = 0;
    settle(); tick();
    access_update_en = 0;
    fill_set = 7; settle(); check_eq("acc_set7", fill_way, 2);
    fill_set = 6; settle(); check_eq("acc_set6", fill_way, 0);

    // Same-set fill and access update in one cycle
    access_en = 1; access_set = 3;
    settle(); tick();
    access_en = 0; fill_en = 1; fill_set = 3;
    access_update_en = 1; access_update_way = 2;
    settle(); check_eq("same_pre", fill_way, 0); tick();
    fill_en = 0; access_update_en = 0;
    settle(); check_eq("same_post", fill_way, 1); tick();

    // Random traffic on a few sets so fills and updates collide
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) do_reset();
      fetch_en          = NT'($urandom);
      update_lru        = 1'($urandom);
      miss_en           = ($urandom_range(0, 2) == 0);
      miss_thread_idx   = 2'($urandom);
      wake_bitmap       = NT'($urandom & $urandom & $urandom);
      fill_en           = 1'($urandom);
      fill_set          = 6'($urandom_range(0, 7));
      access_en         = 1'($urandom);
      access_set        = 6'($urandom_range(0, 7));
      access_update_en  = 1'($urandom);
      access_update_way = 2'($urandom);
      settle();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
